// File: rtl/link_pkg.sv
// Shared types and constants for the board-to-board link session logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package link_pkg;

   // Session states; the 3-bit codes are visible on the state port.
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_PEER  = 3'd1,
      ST_LINKED     = 3'd2,
      ST_START_WAIT = 3'd3,
      ST_PLAYING    = 3'd4,
      ST_WON        = 3'd5,
      ST_LOST       = 3'd6
   } link_state_t;

   // Role reported on status once linked.
   localparam logic MASTER = 1'b0;
   localparam logic SLAVE  = 1'b1;

   // Larger of two integers, used to size the shared timeout counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/link_rx_sync.sv
// Brings one asynchronous peer line into the clock domain and glitch-filters it.
// Latency: 2 + FILTER_LEN cycles from pin change to rx change; shorter pulses are dropped.
// Backpressure: none, free-running sampler.
module link_rx_sync #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic async_line,
   output logic rx
);

   // Run counter only needs to reach FILTER_LEN-1.
   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] run_cnt;

   // Two-flop synchroniser against metastability on the raw pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= async_line;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after FILTER_LEN consecutive samples disagree with rx.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_cnt <= '0;
         rx      <= 1'b0;
      end else if (sync2 != rx) begin
         if (run_cnt == RUN_LAST) begin
            rx      <= sync2;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + CW'(1);
         end
      end else begin
         run_cnt <= '0;
      end
   end

endmodule

// File: rtl/link_session_ctrl.sv
// Sequences the two-board link (connect/start/finish) and decides master/slave role.
// Latency: outputs registered, change on the transition edge; peer inputs add 2+FILTER_LEN cycles.
// Backpressure: none; request pulses in states that do not use them are dropped.
module link_session_ctrl
   import link_pkg::*;
#(
   parameter int   FILTER_LEN      = 4,
   parameter int   CONNECT_TIMEOUT = 100000000,
   parameter int   START_TIMEOUT   = 10000000,
   parameter int   TIE_WINDOW      = 8,
   parameter logic BOARD_ID        = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_connect,
   input  logic       req_start,
   input  logic       req_return,
   input  logic       local_finish,
   input  logic       receive_connect,
   input  logic       receive_start,
   input  logic       receive_game_finish,
   output logic       send_connect,
   output logic       send_start,
   output logic       send_game_finish,
   output logic       status,
   output logic       game_init,
   output logic       link_up,
   output logic       timeout,
   output logic [2:0] state
);

   localparam int TMAX = max_int(CONNECT_TIMEOUT, START_TIMEOUT);
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] CONN_LAST  = TW'(CONNECT_TIMEOUT - 1);
   localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
   // Tie counter saturates one past the window so "outside" stays distinguishable.
   localparam int KW = $clog2(TIE_WINDOW + 2);
   localparam logic [KW-1:0] TIE_LAST = KW'(TIE_WINDOW);

   link_state_t   st;
   logic [TW-1:0] tcnt;
   logic [KW-1:0] tie_cnt;
   logic          slave_pending;
   logic          rx_connect;
   logic          rx_start;
   logic          rx_game_finish;

   link_rx_sync #(.FILTER_LEN(FILTER_LEN)) u_rx_connect (
      .clk        (clk),
      .rst        (rst),
      .async_line (receive_connect),
      .rx         (rx_connect)
   );

   link_rx_sync #(.FILTER_LEN(FILTER_LEN)) u_rx_start (
      .clk        (clk),
      .rst        (rst),
      .async_line (receive_start),
      .rx         (rx_start)
   );

   link_rx_sync #(.FILTER_LEN(FILTER_LEN)) u_rx_game_finish (
      .clk        (clk),
      .rst        (rst),
      .async_line (receive_game_finish),
      .rx         (rx_game_finish)
   );

   assign state = st;

   // Session FSM with its counters and registered outputs; the link-loss block at the end overrides the case.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st               <= ST_IDLE;
         tcnt             <= '0;
         tie_cnt          <= '0;
         slave_pending    <= 1'b0;
         send_connect     <= 1'b0;
         send_start       <= 1'b0;
         send_game_finish <= 1'b0;
         status           <= 1'b0;
         game_init        <= 1'b0;
         link_up          <= 1'b0;
         timeout          <= 1'b0;
      end else begin
         game_init <= 1'b0;
         timeout   <= 1'b0;
         if (tcnt != '1) tcnt <= tcnt + TW'(1);
         if (tie_cnt <= TIE_LAST) tie_cnt <= tie_cnt + KW'(1);

         case (st)
            ST_IDLE: begin
               if (req_connect) begin
                  st            <= ST_WAIT_PEER;
                  tcnt          <= '0;
                  tie_cnt       <= '0;
                  send_connect  <= 1'b1;
                  slave_pending <= rx_connect;
               end
            end
            ST_WAIT_PEER: begin
               if (rx_connect) begin
                  st      <= ST_LINKED;
                  tcnt    <= '0;
                  link_up <= 1'b1;
                  // tie_cnt here equals the cycles between our request and the peer's rise.
                  status  <= (!slave_pending && tie_cnt <= TIE_LAST) ? BOARD_ID : slave_pending;
               end else if (req_return) begin
                  st           <= ST_IDLE;
                  tcnt         <= '0;
                  send_connect <= 1'b0;
               end else if (tcnt == CONN_LAST) begin
                  st           <= ST_IDLE;
                  tcnt         <= '0;
                  send_connect <= 1'b0;
                  timeout      <= 1'b1;
               end
            end
            ST_LINKED: begin
               if (req_return) begin
                  st               <= ST_IDLE;
                  tcnt             <= '0;
                  send_connect     <= 1'b0;
                  send_start       <= 1'b0;
                  send_game_finish <= 1'b0;
                  link_up          <= 1'b0;
               end else if (status == MASTER) begin
                  if (req_start) begin
                     st         <= ST_START_WAIT;
                     tcnt       <= '0;
                     send_start <= 1'b1;
                  end
               end else if (rx_start) begin
                  st         <= ST_PLAYING;
                  tcnt       <= '0;
                  send_start <= 1'b1;
                  game_init  <= 1'b1;
               end
            end
            ST_START_WAIT: begin
               if (rx_start) begin
                  st        <= ST_PLAYING;
                  tcnt      <= '0;
                  game_init <= 1'b1;
               end else if (req_return) begin
                  st         <= ST_LINKED;
                  tcnt       <= '0;
                  send_start <= 1'b0;
               end else if (tcnt == START_LAST) begin
                  st         <= ST_LINKED;
                  tcnt       <= '0;
                  send_start <= 1'b0;
                  timeout    <= 1'b1;
               end
            end
            ST_PLAYING: begin
               if (local_finish) begin
                  st               <= ST_WON;
                  tcnt             <= '0;
                  send_game_finish <= 1'b1;
               end else if (rx_game_finish) begin
                  st   <= ST_LOST;
                  tcnt <= '0;
               end
            end
            ST_WON, ST_LOST: begin
               if (req_return) begin
                  st               <= ST_LINKED;
                  tcnt             <= '0;
                  send_start       <= 1'b0;
                  send_game_finish <= 1'b0;
               end
            end
            default: begin
               st   <= ST_IDLE;
               tcnt <= '0;
            end
         endcase

         // Losing the peer's connect line wins over everything once linked.
         if (!rx_connect && (st inside {ST_LINKED, ST_START_WAIT, ST_PLAYING, ST_WON, ST_LOST})) begin
            st               <= ST_IDLE;
            tcnt             <= '0;
            send_connect     <= 1'b0;
            send_start       <= 1'b0;
            send_game_finish <= 1'b0;
            link_up          <= 1'b0;
            game_init        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_link_session_ctrl.sv
// Directed bench: cross-wired board pair A/B plus a standalone board C with bench-driven peer lines.
// Latency: n/a.
// Backpressure: n/a.
module tb_link_session_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic a_req_connect = 0, a_req_start = 0, a_req_return = 0, a_local_finish = 0;
   logic b_req_connect = 0, b_req_start = 0, b_req_return = 0, b_local_finish = 0;
   logic c_req_connect = 0, c_req_start = 0, c_req_return = 0, c_local_finish = 0;
   logic c_rcv_connect = 0, c_rcv_start = 0, c_rcv_gf = 0;

   logic a_send_connect, a_send_start, a_send_gf, a_status, a_game_init, a_link_up, a_timeout;
   logic b_send_connect, b_send_start, b_send_gf, b_status, b_game_init, b_link_up, b_timeout;
   logic c_send_connect, c_send_start, c_send_gf, c_status, c_game_init, c_link_up, c_timeout;
   logic [2:0] a_state, b_state, c_state;

   link_session_ctrl #(.FILTER_LEN(2), .CONNECT_TIMEOUT(50), .START_TIMEOUT(20), .TIE_WINDOW(4), .BOARD_ID(1'b0)) u_a (
      .clk(clk), .rst(rst), .req_connect(a_req_connect), .req_start(a_req_start), .req_return(a_req_return),
      .local_finish(a_local_finish), .receive_connect(b_send_connect), .receive_start(b_send_start),
      .receive_game_finish(b_send_gf), .send_connect(a_send_connect), .send_start(a_send_start),
      .send_game_finish(a_send_gf), .status(a_status), .game_init(a_game_init), .link_up(a_link_up),
      .timeout(a_timeout), .state(a_state)
   );

   link_session_ctrl #(.FILTER_LEN(2), .CONNECT_TIMEOUT(50), .START_TIMEOUT(20), .TIE_WINDOW(4), .BOARD_ID(1'b1)) u_b (
      .clk(clk), .rst(rst), .req_connect(b_req_connect), .req_start(b_req_start), .req_return(b_req_return),
      .local_finish(b_local_finish), .receive_connect(a_send_connect), .receive_start(a_send_start),
      .receive_game_finish(a_send_gf), .send_connect(b_send_connect), .send_start(b_send_start),
      .send_game_finish(b_send_gf), .status(b_status), .game_init(b_game_init), .link_up(b_link_up),
      .timeout(b_timeout), .state(b_state)
   );

   link_session_ctrl #(.FILTER_LEN(2), .CONNECT_TIMEOUT(50), .START_TIMEOUT(20), .TIE_WINDOW(4), .BOARD_ID(1'b0)) u_c (
      .clk(clk), .rst(rst), .req_connect(c_req_connect), .req_start(c_req_start), .req_return(c_req_return),
      .local_finish(c_local_finish), .receive_connect(c_rcv_connect), .receive_start(c_rcv_start),
      .receive_game_finish(c_rcv_gf), .send_connect(c_send_connect), .send_start(c_send_start),
      .send_game_finish(c_send_gf), .status(c_status), .game_init(c_game_init), .link_up(c_link_up),
      .timeout(c_timeout), .state(c_state)
   );

   // game_init pulse counters, sampled mid-cycle.
   int a_gi = 0, b_gi = 0;
   always @(negedge clk) begin
      if (a_game_init) a_gi++;
      if (b_game_init) b_gi++;
   end

   // Advance n rising edges and settle on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(2);
      n_tests++; if (a_state !== 3'd0) begin n_fail++; $display("FAIL reset_a_state got %0d want 0", a_state); end
      n_tests++; if ({a_send_connect, a_send_start, a_send_gf, a_status, a_game_init, a_link_up, a_timeout} !== 7'b0) begin
         n_fail++; $display("FAIL reset_a_outputs got %b want 0000000", {a_send_connect, a_send_start, a_send_gf, a_status, a_game_init, a_link_up, a_timeout}); end
      rst = 1'b1;
      step(3);
      n_tests++; if (c_state !== 3'd0) begin n_fail++; $display("FAIL reset_c_state got %0d want 0", c_state); end
      n_tests++; if ({c_send_connect, c_link_up, c_timeout} !== 3'b0) begin n_fail++; $display("FAIL reset_c_outputs got %b want 000", {c_send_connect, c_link_up, c_timeout}); end
   endtask

   // A requests first, B 30 cycles later: A master, B slave.
   task automatic test_connect_order();
      a_req_connect = 1; step(1); a_req_connect = 0;
      n_tests++; if (a_state !== 3'd1) begin n_fail++; $display("FAIL t1_a_wait got %0d want 1", a_state); end
      n_tests++; if (a_send_connect !== 1'b1) begin n_fail++; $display("FAIL t1_a_send_connect got %0d want 1", a_send_connect); end
      step(29);
      b_req_connect = 1; step(1); b_req_connect = 0;
      n_tests++; if (b_state !== 3'd1) begin n_fail++; $display("FAIL t1_b_wait got %0d want 1", b_state); end
      step(1);
      n_tests++; if (b_state !== 3'd2) begin n_fail++; $display("FAIL t1_b_linked got %0d want 2", b_state); end
      n_tests++; if (b_status !== 1'b1) begin n_fail++; $display("FAIL t1_b_status got %0d want 1", b_status); end
      n_tests++; if (b_link_up !== 1'b1) begin n_fail++; $display("FAIL t1_b_link_up got %0d want 1", b_link_up); end
      n_tests++; if (a_state !== 3'd1) begin n_fail++; $display("FAIL t1_a_still_wait got %0d want 1", a_state); end
      step(4);
      n_tests++; if (a_state !== 3'd2) begin n_fail++; $display("FAIL t1_a_linked got %0d want 2", a_state); end
      n_tests++; if (a_status !== 1'b0) begin n_fail++; $display("FAIL t1_a_status got %0d want 0", a_status); end
      n_tests++; if (a_link_up !== 1'b1) begin n_fail++; $display("FAIL t1_a_link_up got %0d want 1", a_link_up); end
   endtask

   // Master start, slave echo; one game_init per board.
   task automatic test_start_handshake();
      int ga, gb;
      ga = a_gi; gb = b_gi;
      a_req_start = 1; step(1); a_req_start = 0;
      n_tests++; if (a_state !== 3'd3) begin n_fail++; $display("FAIL t2_a_start_wait got %0d want 3", a_state); end
      n_tests++; if (a_send_start !== 1'b1) begin n_fail++; $display("FAIL t2_a_send_start got %0d want 1", a_send_start); end
      step(4);
      n_tests++; if (b_state !== 3'd2) begin n_fail++; $display("FAIL t2_b_still_linked got %0d want 2", b_state); end
      step(1);
      n_tests++; if (b_state !== 3'd4) begin n_fail++; $display("FAIL t2_b_playing got %0d want 4", b_state); end
      n_tests++; if ({b_send_start, b_game_init} !== 2'b11) begin n_fail++; $display("FAIL t2_b_echo_init got %b want 11", {b_send_start, b_game_init}); end
      step(10);
      n_tests++; if (a_state !== 3'd4) begin n_fail++; $display("FAIL t2_a_playing got %0d want 4", a_state); end
      n_tests++; if (a_gi - ga !== 1) begin n_fail++; $display("FAIL t2_a_init_count got %0d want 1", a_gi - ga); end
      n_tests++; if (b_gi - gb !== 1) begin n_fail++; $display("FAIL t2_b_init_count got %0d want 1", b_gi - gb); end
   endtask

   // Simultaneous requests fall inside the tie window: status follows BOARD_ID.
   task automatic test_tie();
      do_reset();
      a_req_connect = 1; b_req_connect = 1; step(1); a_req_connect = 0; b_req_connect = 0;
      step(4);
      n_tests++; if ({a_state, b_state} !== {3'd1, 3'd1}) begin n_fail++; $display("FAIL tie_wait got %0d/%0d want 1/1", a_state, b_state); end
      step(1);
      n_tests++; if ({a_state, b_state} !== {3'd2, 3'd2}) begin n_fail++; $display("FAIL tie_linked got %0d/%0d want 2/2", a_state, b_state); end
      n_tests++; if ({a_status, b_status} !== 2'b01) begin n_fail++; $display("FAIL tie_status got %b want 01", {a_status, b_status}); end
   endtask

   // No peer: timeout pulse on the 50th cycle in WAIT_PEER.
   task automatic test_connect_timeout();
      c_req_connect = 1; step(1); c_req_connect = 0;
      step(49);
      n_tests++; if ({c_state, c_timeout} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL t3_before got state %0d to %0d want 1/0", c_state, c_timeout); end
      step(1);
      n_tests++; if (c_timeout !== 1'b1) begin n_fail++; $display("FAIL t3_pulse got %0d want 1", c_timeout); end
      n_tests++; if ({c_state, c_send_connect} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL t3_idle got state %0d sc %0d want 0/0", c_state, c_send_connect); end
      step(1);
      n_tests++; if (c_timeout !== 1'b0) begin n_fail++; $display("FAIL t3_pulse_width got %0d want 0", c_timeout); end
   endtask

   // Bring C up as slave and into PLAYING via bench-driven peer lines.
   task automatic c_to_playing();
      c_rcv_gf = 0; c_rcv_start = 0; c_rcv_connect = 1;
      step(6);
      c_req_connect = 1; step(1); c_req_connect = 0;
      step(1);
      c_rcv_start = 1;
      step(6);
   endtask

   task automatic test_glitch_and_drop();
      c_to_playing();
      n_tests++; if ({c_state, c_status, c_send_start} !== {3'd4, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL t5_setup got state %0d status %0d ss %0d want 4/1/1", c_state, c_status, c_send_start); end
      c_rcv_connect = 0; step(1); c_rcv_connect = 1;
      step(8);
      n_tests++; if (c_state !== 3'd4) begin n_fail++; $display("FAIL t5_glitch got %0d want 4", c_state); end
      c_rcv_connect = 0;
      step(4);
      n_tests++; if (c_state !== 3'd4) begin n_fail++; $display("FAIL t5_drop_latency got %0d want 4", c_state); end
      step(1);
      n_tests++; if (c_state !== 3'd0) begin n_fail++; $display("FAIL t5_drop_idle got %0d want 0", c_state); end
      n_tests++; if ({c_send_connect, c_send_start, c_send_gf, c_link_up} !== 4'b0) begin
         n_fail++; $display("FAIL t5_drop_outputs got %b want 0000", {c_send_connect, c_send_start, c_send_gf, c_link_up}); end
      step(5);
   endtask

   // Local finish and qualified peer finish seen on the same edge: local wins.
   task automatic test_finish_priority();
      c_to_playing();
      n_tests++; if (c_state !== 3'd4) begin n_fail++; $display("FAIL t4_setup got %0d want 4", c_state); end
      c_rcv_gf = 1;
      step(4);
      n_tests++; if (c_state !== 3'd4) begin n_fail++; $display("FAIL t4_gf_latency got %0d want 4", c_state); end
      c_local_finish = 1; step(1); c_local_finish = 0;
      n_tests++; if ({c_state, c_send_gf} !== {3'd5, 1'b1}) begin n_fail++; $display("FAIL t4_won got state %0d sgf %0d want 5/1", c_state, c_send_gf); end
      step(2);
      n_tests++; if ({c_state, c_send_gf} !== {3'd5, 1'b1}) begin n_fail++; $display("FAIL t4_hold got state %0d sgf %0d want 5/1", c_state, c_send_gf); end
      c_req_return = 1; step(1); c_req_return = 0;
      n_tests++; if ({c_state, c_send_start, c_send_gf} !== {3'd2, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL t4_return got state %0d ss %0d sgf %0d want 2/0/0", c_state, c_send_start, c_send_gf); end
   endtask

   // C as master: start timeout, then async reset in the middle of START_WAIT.
   task automatic test_start_timeout_and_async_reset();
      c_rcv_connect = 0; c_rcv_start = 0; c_rcv_gf = 0;
      do_reset();
      c_req_connect = 1; step(1); c_req_connect = 0;
      step(8);
      c_rcv_connect = 1;
      step(6);
      n_tests++; if ({c_state, c_status} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL t6_master got state %0d status %0d want 2/0", c_state, c_status); end
      c_req_start = 1; step(1); c_req_start = 0;
      n_tests++; if ({c_state, c_send_start} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL t6_start_wait got state %0d ss %0d want 3/1", c_state, c_send_start); end
      step(19);
      n_tests++; if ({c_state, c_timeout} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL t6_before_to got state %0d to %0d want 3/0", c_state, c_timeout); end
      step(1);
      n_tests++; if ({c_state, c_timeout, c_send_start} !== {3'd2, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL t6_start_to got state %0d to %0d ss %0d want 2/1/0", c_state, c_timeout, c_send_start); end
      c_req_start = 1; step(1); c_req_start = 0;
      step(2);
      n_tests++; if (c_state !== 3'd3) begin n_fail++; $display("FAIL t6_rewait got %0d want 3", c_state); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if (c_state !== 3'd0) begin n_fail++; $display("FAIL t6_arst_state got %0d want 0", c_state); end
      n_tests++; if ({c_send_connect, c_send_start, c_send_gf, c_status, c_game_init, c_link_up, c_timeout} !== 7'b0) begin
         n_fail++; $display("FAIL t6_arst_outputs got %b want 0000000", {c_send_connect, c_send_start, c_send_gf, c_status, c_game_init, c_link_up, c_timeout}); end
      step(1);
      rst = 1'b1;
      step(1);
   endtask

   initial begin
      test_reset();
      test_connect_order();
      test_start_handshake();
      test_tie();
      test_connect_timeout();
      test_glitch_and_drop();
      test_finish_priority();
      test_start_timeout_and_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
